// File: rtl/conv_event_sender.sv
// conv_event_sender: buffers upstream spike events in a FIFO and presents them
// one at a time on the Convolution2d event_in/event_valid/event_ack handshake.
// Zero-spike and out-of-image events are filtered at the input.
// Optional: define CONV_EVENT_SENDER_TIMEOUT_EN to drop events whose ack does
// not arrive within ACK_TIMEOUT cycles (adds the drop_count output).
module conv_event_sender #(
  parameter int unsigned COORD_BITS  = 8,
  parameter int unsigned IN_CHANNELS = 8,
  parameter int unsigned IMG_WIDTH   = 32,
  parameter int unsigned IMG_HEIGHT  = 32,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned ACK_TIMEOUT = 64
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [COORD_BITS-1:0]                 in_x,
  input  logic [COORD_BITS-1:0]                 in_y,
  input  logic [IN_CHANNELS-1:0]                in_spikes,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic [2*COORD_BITS+IN_CHANNELS-1:0]   event_out,
  output logic                                  event_valid,
  input  logic                                  event_ack,
  output logic [$clog2(FIFO_DEPTH):0]           fifo_count,
  output logic                                  busy,
  output logic                                  coord_err,
  input  logic                                  clr_status
`ifdef CONV_EVENT_SENDER_TIMEOUT_EN
  ,output logic [15:0]                          drop_count
`endif
);

  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned EW    = 2*COORD_BITS + IN_CHANNELS;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [COORD_BITS:0] X_LIM = (COORD_BITS+1)'(IMG_WIDTH);
  localparam logic [COORD_BITS:0] Y_LIM = (COORD_BITS+1)'(IMG_HEIGHT);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t         state;
  logic [EW-1:0]  mem [FIFO_DEPTH];
  logic [AW:0]    wr_ptr, rd_ptr;
  logic [AW:0]    cnt_nxt;
  logic           accept, out_of_range, push, pop, empty;

  assign fifo_count   = wr_ptr - rd_ptr;
  assign empty        = (fifo_count == '0);
  assign accept       = in_valid && in_ready;
  assign out_of_range = ({1'b0, in_x} >= X_LIM) || ({1'b0, in_y} >= Y_LIM);
  assign push         = accept && (in_spikes != '0) && !out_of_range;
  assign pop          = !empty && ((state == IDLE) || (state == GAP));
  assign busy         = (state != IDLE) || !empty;

  // Occupancy after this edge, used to register the full flag
  always_comb begin
    cnt_nxt = fifo_count;
    if (push) cnt_nxt = cnt_nxt + (AW+1)'(1);
    if (pop)  cnt_nxt = cnt_nxt - (AW+1)'(1);
  end

  // FIFO storage write port
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {in_x, in_y, in_spikes};
  end

  // FIFO pointers (extra MSB distinguishes full from empty)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Registered ready: !full of the state after this edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) in_ready <= 1'b0;
    else        in_ready <= (cnt_nxt != DEPTH_C);
  end

  // Sticky coordinate error; a new error beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         coord_err <= 1'b0;
    else if (accept && out_of_range)    coord_err <= 1'b1;
    else if (clr_status)                coord_err <= 1'b0;
  end

`ifdef CONV_EVENT_SENDER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);
  logic [TW-1:0] tmo_cnt;
`endif

  // Handshake FSM: IDLE -> SEND (hold until ack) -> GAP (one low cycle)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      event_out   <= '0;
      event_valid <= 1'b0;
`ifdef CONV_EVENT_SENDER_TIMEOUT_EN
      tmo_cnt     <= '0;
      drop_count  <= '0;
`endif
    end else begin
`ifdef CONV_EVENT_SENDER_TIMEOUT_EN
      if (clr_status) drop_count <= '0;
`endif
      case (state)
        IDLE, GAP: begin
          if (pop) begin
            event_out   <= mem[rd_ptr[AW-1:0]];
            event_valid <= 1'b1;
            state       <= SEND;
`ifdef CONV_EVENT_SENDER_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
          end else begin
            state <= IDLE;
          end
        end
        SEND: begin
          if (event_ack) begin
            event_valid <= 1'b0;
            state       <= GAP;
          end
`ifdef CONV_EVENT_SENDER_TIMEOUT_EN
          // Ack on the timeout edge wins over the drop
          else if (tmo_cnt == TMO_LAST) begin
            event_valid <= 1'b0;
            state       <= GAP;
            if (!clr_status && drop_count != '1) drop_count <= drop_count + 16'd1;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
`endif
        end
        default: begin
          state       <= IDLE;
          event_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_event_sender.sv
// Directed bench for conv_event_sender (default parameters, FIFO_DEPTH=16).
module tb_conv_event_sender;

  localparam int unsigned CB = 8;
  localparam int unsigned IC = 8;
  localparam int unsigned EW = 2*CB + IC;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CB-1:0] in_x, in_y;
  logic [IC-1:0] in_spikes;
  logic          in_valid, in_ready;
  logic [EW-1:0] event_out;
  logic          event_valid, event_ack;
  logic [4:0]    fifo_count;
  logic          busy, coord_err, clr_status;
`ifdef CONV_EVENT_SENDER_TIMEOUT_EN
  logic [15:0]   drop_count;
`endif

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  conv_event_sender #(
    .COORD_BITS(CB), .IN_CHANNELS(IC), .IMG_WIDTH(32), .IMG_HEIGHT(32),
    .FIFO_DEPTH(16), .ACK_TIMEOUT(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_x(in_x), .in_y(in_y), .in_spikes(in_spikes),
    .in_valid(in_valid), .in_ready(in_ready), .event_out(event_out),
    .event_valid(event_valid), .event_ack(event_ack), .fifo_count(fifo_count),
    .busy(busy), .coord_err(coord_err), .clr_status(clr_status)
`ifdef CONV_EVENT_SENDER_TIMEOUT_EN
    , .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ev(input int unsigned x, input int unsigned y, input int unsigned s);
    logic [EW-1:0] e;
    e = {CB'(x), CB'(y), IC'(s)};
    return 32'(e);
  endfunction

  task automatic drive(input int unsigned x, input int unsigned y, input int unsigned s);
    in_x = CB'(x); in_y = CB'(y); in_spikes = IC'(s); in_valid = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; in_x = '0; in_y = '0; in_spikes = '0; in_valid = 1'b0;
    event_ack = 1'b0; clr_status = 1'b0;
    step(); step();
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_valid", 32'(event_valid), 0);
    chk("rst_out", 32'(event_out), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cerr", 32'(coord_err), 0);
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", 32'(in_ready), 1);

    // ---- single event, ack two cycles after valid ----
    drive(2, 3, 5);
    step();
    in_valid = 1'b0;
    chk("single_cnt1", 32'(fifo_count), 1);
    chk("single_novalid", 32'(event_valid), 0);
    step();
    chk("single_valid", 32'(event_valid), 1);
    chk("single_data", 32'(event_out), ev(2, 3, 5));
    chk("single_cnt0", 32'(fifo_count), 0);
    chk("single_busy", 32'(busy), 1);
    step();
    chk("single_hold1", 32'(event_out), ev(2, 3, 5));
    step();
    chk("single_hold2", 32'(event_valid), 1);
    event_ack = 1'b1;
    step();
    event_ack = 1'b0;
    chk("single_fall", 32'(event_valid), 0);
    step();
    chk("single_idle_busy", 32'(busy), 0);
    chk("single_idle_cnt", 32'(fifo_count), 0);

    // ---- fill: 17 events with ack low ----
    for (int i = 0; i < 17; i++) begin
      chk("fill_ready", 32'(in_ready), 1);
      drive(i, i + 1, i + 1);
      step();
    end
    in_valid = 1'b0;
    chk("full_count", 32'(fifo_count), 16);
    chk("full_ready", 32'(in_ready), 0);
    chk("full_head", 32'(event_out), ev(0, 1, 1));
    drive(20, 20, 20);
    step();
    in_valid = 1'b0;
    chk("full_nopush", 32'(fifo_count), 16);
    for (int i = 0; i < 17; i++) begin
      chk("drain_valid", 32'(event_valid), 1);
      chk("drain_data", 32'(event_out), ev(i, i + 1, i + 1));
      event_ack = 1'b1;
      step();
      event_ack = 1'b0;
      chk("drain_gap", 32'(event_valid), 0);
      step();
      if (i == 0) chk("drain_ready", 32'(in_ready), 1);
    end
    chk("drain_idle_valid", 32'(event_valid), 0);
    chk("drain_idle_cnt", 32'(fifo_count), 0);
    chk("drain_idle_busy", 32'(busy), 0);

    // ---- filtering ----
    drive(1, 1, 0);
    step();
    drive(32, 0, 1);
    step();
    in_valid = 1'b0;
    chk("filt_cerr", 32'(coord_err), 1);
    chk("filt_cnt", 32'(fifo_count), 0);
    drive(0, 32, 1);
    step();
    in_valid = 1'b0;
    step(); step();
    chk("filt_novalid", 32'(event_valid), 0);
    chk("filt_busy", 32'(busy), 0);
    clr_status = 1'b1;
    step();
    clr_status = 1'b0;
    chk("clr_cerr", 32'(coord_err), 0);
    drive(40, 2, 3); clr_status = 1'b1;
    step();
    in_valid = 1'b0; clr_status = 1'b0;
    chk("set_wins", 32'(coord_err), 1);
    clr_status = 1'b1;
    step();
    clr_status = 1'b0;
    chk("clr_cerr2", 32'(coord_err), 0);

    // ---- ack outside SEND; boundary coordinates accepted ----
    event_ack = 1'b1;
    step();
    event_ack = 1'b0;
    chk("idle_ack_valid", 32'(event_valid), 0);
    chk("idle_ack_busy", 32'(busy), 0);
    drive(31, 31, 8'h80);
    step();
    drive(0, 0, 1);
    step();
    in_valid = 1'b0;
    chk("edge_valid", 32'(event_valid), 1);
    chk("edge_data", 32'(event_out), ev(31, 31, 8'h80));
    chk("edge_cnt", 32'(fifo_count), 1);
    event_ack = 1'b1;
    step();
    chk("gap_valid", 32'(event_valid), 0);
    chk("gap_cnt", 32'(fifo_count), 1);
    step();
    event_ack = 1'b0;
    chk("gap_ack_ign_valid", 32'(event_valid), 1);
    chk("gap_ack_ign_data", 32'(event_out), ev(0, 0, 1));
    chk("gap_ack_ign_cnt", 32'(fifo_count), 0);
    step();
    chk("b_held", 32'(event_valid), 1);
    event_ack = 1'b1;
    step();
    chk("ack3_gap", 32'(event_valid), 0);
    chk("ack3_busy", 32'(busy), 1);
    step();
    step();
    event_ack = 1'b0;
    chk("ack3_valid", 32'(event_valid), 0);
    chk("ack3_idle", 32'(busy), 0);
    drive(5, 6, 7);
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("post_idle_ack_valid", 32'(event_valid), 1);
    chk("post_idle_ack_data", 32'(event_out), ev(5, 6, 7));
    event_ack = 1'b1;
    step();
    event_ack = 1'b0;
    step();

    // ---- reset mid-operation ----
    for (int i = 0; i < 6; i++) begin
      drive(i + 3, i, i + 9);
      step();
    end
    in_valid = 1'b0;
    chk("pre_rst_cnt", 32'(fifo_count), 5);
    chk("pre_rst_valid", 32'(event_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(event_valid), 0);
    chk("mid_rst_out", 32'(event_out), 0);
    chk("mid_rst_cnt", 32'(fifo_count), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ready", 32'(in_ready), 0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst2_ready", 32'(in_ready), 1);
    step(); step(); step();
    chk("post_rst2_valid", 32'(event_valid), 0);
    chk("post_rst2_busy", 32'(busy), 0);

`ifdef CONV_EVENT_SENDER_TIMEOUT_EN
    // ---- timeout: drop after 8 SEND cycles, ack on 8th wins ----
    drive(1, 2, 3);
    step();
    in_valid = 1'b0;
    step();
    chk("tmo_send", 32'(event_valid), 1);
    for (int i = 0; i < 7; i++) step();
    chk("tmo_hold", 32'(event_valid), 1);
    step();
    chk("tmo_drop_valid", 32'(event_valid), 0);
    chk("tmo_drop_cnt", 32'(drop_count), 1);
    step();
    drive(4, 4, 4);
    step();
    in_valid = 1'b0;
    step();
    for (int i = 0; i < 7; i++) step();
    event_ack = 1'b1;
    step();
    event_ack = 1'b0;
    chk("tmo_ack8_valid", 32'(event_valid), 0);
    chk("tmo_ack8_cnt", 32'(drop_count), 1);
    clr_status = 1'b1;
    step();
    clr_status = 1'b0;
    chk("tmo_clr", 32'(drop_count), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/conv_event_sender.md
Name: conv_event_sender

Overview:
- Transmit end of the convolution event handshake: buffers spike events from the upstream spike source and presents them one at a time on the event_in / event_valid / event_ack port of Convolution2d.
- Filters events that cannot produce work: all-zero spike vectors and out-of-image coordinates.
- Guarantees stable data while valid is high and a mandatory low gap after each ack, so the receiver re-arms between events.

Parameters:
- COORD_BITS, DEFAULT_COORD_BITS, width of each x/y coordinate
- IN_CHANNELS, DEFAULT_IN_CHANNELS, width of the spike vector
- IMG_WIDTH, DEFAULT_IMG_WIDTH, valid x range 0..IMG_WIDTH-1
- IMG_HEIGHT, DEFAULT_IMG_HEIGHT, valid y range 0..IMG_HEIGHT-1
- FIFO_DEPTH, 16, event buffer entries; power of two, >= 2
- ACK_TIMEOUT, 64, cycles to wait for ack (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_x  in  COORD_BITS  upstream event x
- in_y  in  COORD_BITS  upstream event y
- in_spikes  in  IN_CHANNELS  upstream spike vector
- in_valid  in  1  upstream event present
- in_ready  out  1  sender can accept (registered, = !fifo_full)
- event_out  out  output_vector_t  {x, y, spikes} to the conv event_in
- event_valid  out  1  event_out valid
- event_ack  in  1  receiver accepted the current event
- fifo_count  out  $clog2(FIFO_DEPTH)+1  buffered entries, excluding the in-flight event
- busy  out  1  state != IDLE or fifo_count != 0
- coord_err  out  1  sticky: an out-of-range event was dropped
- clr_status  in  1  synchronous clear of coord_err (and of drop_count if enabled)

Behaviour:
Reset:
- in_ready=0 during reset, 1 on the first cycle after reset.
- event_out=0, event_valid=0, fifo_count=0, busy=0, coord_err=0.
- FIFO pointers cleared; state=IDLE.
- Reset mid-transfer drops every buffered and in-flight event, with no ack required.

Input side:
- Transfer occurs on a rising edge with in_valid && in_ready.
- in_ready depends only on the registered full flag. A pop in the same cycle does not make room; deterministic, no combinational path.
- Accepted events with in_spikes==0 are discarded silently and not stored.
- Accepted events with in_x>=IMG_WIDTH or in_y>=IMG_HEIGHT are discarded and set coord_err. coord_err is also set in the same cycle as clr_status; set wins.
- Every other accepted event is pushed, in arrival order.

FSM:
- IDLE:
  - If the FIFO is non-empty, pop the head into the event_out register, set event_valid=1, go to SEND.
  - Latency: an event accepted into an empty FIFO at edge N gives event_valid=1 after edge N+1.
- SEND:
  - event_out and event_valid are held constant.
  - If event_ack==1 is sampled at an edge, clear event_valid and go to GAP.
  - No other exit (without the optional feature).
- GAP:
  - event_valid=0 for exactly one cycle.
  - Next edge: if the FIFO is non-empty, pop and go to SEND (back-to-back rate: one event per 2 cycles plus the receiver's ack latency); else go to IDLE.

Handshake and ordering rules:
- event_ack sampled in IDLE or GAP is ignored.
- A multi-cycle ack counts once; the GAP cycle absorbs it.
- A push and a pop in the same cycle are both performed; fifo_count is unchanged.
- A pop never occurs when empty; a push never occurs when full.
- Pointer wrap-around uses the extra MSB for the full/empty distinction.
- FIFO order is strict; no reordering or coalescing.

Optional Feature:
- Macro: CONV_EVENT_SENDER_TIMEOUT_EN.
- When defined:
  - A counter runs in SEND.
  - If no ack arrives within ACK_TIMEOUT cycles of entering SEND, the event is dropped: event_valid falls, the FSM goes to GAP, and drop_count increments.
  - drop_count is an output port, 16 bits, saturating; cleared by reset or clr_status.
  - An ack sampled on the same edge as the timeout counts as an ack, not a drop.
- When undefined:
  - SEND waits indefinitely.
  - The drop_count port does not exist.

Test Plan:
- Single event (x=2,y=3,spikes=0b0101) into an empty sender, ack 2 cycles after valid rises:
  - event_valid rises the edge after acceptance, holds event_out stable, falls the edge after ack.
  - fifo_count returns to 0 and busy=0.
- 16 events pushed with ack held low (FIFO_DEPTH=16):
  - The first moves to SEND; 15 entries are buffered.
  - A 17th push is accepted and in_ready drops after the 17th, with fifo_count=16.
  - Then acking every SEND drains all 17 events in order, each separated by exactly one low-valid cycle.
- Drop filtering:
  - Event with spikes=0: accepted but never emitted.
  - Event with x=IMG_WIDTH: accepted, never emitted, coord_err=1.
  - clr_status pulse: coord_err returns to 0.
- Ack outside SEND:
  - event_ack pulsed in IDLE and in GAP causes no state change or pop.
  - A 3-cycle ack in SEND pops exactly one event.
- Reset mid-operation:
  - Assert rst_n low while in SEND with 5 events buffered.
  - Outputs go to their reset values immediately; after release, no event is emitted without new input.
- With CONV_EVENT_SENDER_TIMEOUT_EN and ACK_TIMEOUT=8, ack never given:
  - Each event drops after 8 cycles and drop_count increments by 1 per event.
  - An ack on the 8th cycle does not increment drop_count.
